// File: rtl/cnn_param_loader.sv
// cnn_param_loader: writes the CNN parameter header into byte RAM, then streams parameter words into it byte by byte
module cnn_param_loader #(
  parameter int MAX_LAYERS = 10,
  parameter int ADDR_W = 16,
  parameter int WORD_W = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                          clk,
  input  logic                          RST,
  input  logic                          cfg_we,
  input  logic                          cfg_dense,
  input  logic [$clog2(MAX_LAYERS)-1:0] cfg_idx,
  input  logic [7:0]                    cfg_data,
  input  logic [7:0]                    num_layers,
  input  logic [7:0]                    filter_size,
  input  logic                          start,
  input  logic                          in_valid,
  input  logic [WORD_W-1:0]             in_data,
  input  logic                          in_last,
  output logic                          in_ready,
  output logic [ADDR_W-1:0]             ram_addr,
  output logic [7:0]                    ram_wdata,
  output logic                          ram_we,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic [ADDR_W-1:0]             filter_offset,
  output logic [ADDR_W-1:0]             dense_offset
);
  localparam int IW = $clog2(MAX_LAYERS);
  localparam int BYTES = WORD_W / 8;
  localparam int AW8 = ADDR_W + 8;
  localparam int XW = ADDR_W + 24;
  localparam logic [7:0] BLAST = 8'(BYTES - 1);
  localparam logic [XW-1:0] AMAX = XW'({ADDR_W{1'b1}});
  localparam logic [ADDR_W:0] PLIM = {1'b0, {ADDR_W{1'b1}}} - (ADDR_W+1)'(BYTES - 1);

  typedef enum logic [2:0] {IDLE, CALC, HDR, STREAM, DONE} st_t;

  st_t               st_q;
  logic [7:0]        ftab_q [MAX_LAYERS];
  logic [7:0]        dtab_q [MAX_LAYERS];
  logic [7:0]        l_q, k_q, cnt_q, bcnt_q, hb, hlen;
  logic [AW8-1:0]    acc_q, acc_d;
  logic [XW-1:0]     foff_x, doff_x;
  logic [ADDR_W:0]   ptr_q;
  logic [WORD_W-1:0] sh_q;
  logic [ADDR_W-1:0] foff_q, doff_q, ram_addr_q;
  logic [7:0]        ram_wdata_q;
  logic [15:0]       kk, fx, dx;
  logic              pend_q, last_q, ram_we_q, done_q, error_q, ovf, word_end;

  // Offset arithmetic, header byte selection and stream handshake
  always_comb begin
    kk = 16'(k_q) * 16'(k_q);
    acc_d = acc_q + AW8'(ftab_q[cnt_q[IW-1:0]]) * (AW8'(kk) + AW8'(1));
    foff_x = XW'({l_q, 1'b0}) + XW'(5);
    doff_x = foff_x + XW'(BYTES) * XW'(acc_d);
    hlen = {l_q[6:0], 1'b0} + 8'd5;
    fx = 16'(foff_q);
    dx = 16'(doff_q);
    hb = cnt_q == 8'd0 ? k_q :
         cnt_q == 8'd1 ? l_q :
         cnt_q == 8'd2 ? fx[15:8] :
         cnt_q == 8'd3 ? fx[7:0] :
         cnt_q == 8'd4 ? dx[15:8] :
         cnt_q == 8'd5 ? dx[7:0] :
         cnt_q < 8'd6 + l_q ? ftab_q[IW'(cnt_q - 8'd6)] : dtab_q[IW'(cnt_q - 8'd6 - l_q)];
    word_end = pend_q && bcnt_q == BLAST;
    ovf = ptr_q > PLIM;
    in_ready = st_q == STREAM && (!pend_q || (word_end && !last_q)) && !ovf;
  end

  // Per-layer count tables, writable only while idle
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < MAX_LAYERS; i++) begin
        ftab_q[i] <= '0;
        dtab_q[i] <= '0;
      end
    end else if (cfg_we && st_q == IDLE && 32'(cfg_idx) < 32'(MAX_LAYERS)) begin
      if (cfg_dense) dtab_q[cfg_idx] <= cfg_data;
      else ftab_q[cfg_idx] <= cfg_data;
    end
  end

  // Load sequencer: offset calculation, header write, byte-serial stream write
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      st_q <= IDLE;
      l_q <= '0;
      k_q <= '0;
      cnt_q <= '0;
      bcnt_q <= '0;
      acc_q <= '0;
      ptr_q <= '0;
      sh_q <= '0;
      pend_q <= 1'b0;
      last_q <= 1'b0;
      foff_q <= '0;
      doff_q <= '0;
      ram_addr_q <= '0;
      ram_wdata_q <= '0;
      ram_we_q <= 1'b0;
      done_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (st_q)
        IDLE: if (start) begin
          l_q <= num_layers;
          k_q <= filter_size;
          acc_q <= '0;
          cnt_q <= '0;
          foff_q <= '0;
          doff_q <= '0;
          error_q <= 1'b0;
          if (num_layers == 8'd0 || 32'(num_layers) > 32'(MAX_LAYERS)) begin
            error_q <= 1'b1;
            done_q <= 1'b1;
            st_q <= DONE;
          end else st_q <= CALC;
        end
        CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 8'd1;
          if (cnt_q == l_q - 8'd1) begin
            foff_q <= foff_x[ADDR_W-1:0];
            doff_q <= doff_x[ADDR_W-1:0];
            if (XW'(BASE_ADDR) + doff_x > AMAX) begin
              error_q <= 1'b1;
              done_q <= 1'b1;
              st_q <= DONE;
            end else begin
              ram_we_q <= 1'b1;
              ram_addr_q <= BASE_ADDR;
              ram_wdata_q <= k_q;
              cnt_q <= 8'd1;
              st_q <= HDR;
            end
          end
        end
        HDR: if (cnt_q == hlen) begin
          ram_we_q <= 1'b0;
          ptr_q <= {1'b0, BASE_ADDR} + {1'b0, foff_q};
          pend_q <= 1'b0;
          st_q <= STREAM;
        end else begin
          ram_we_q <= 1'b1;
          ram_addr_q <= BASE_ADDR + ADDR_W'(cnt_q);
          ram_wdata_q <= hb;
          cnt_q <= cnt_q + 8'd1;
        end
        STREAM: if (word_end && last_q) begin
          ram_we_q <= 1'b0;
          pend_q <= 1'b0;
          done_q <= 1'b1;
          st_q <= DONE;
        end else if (in_valid && (!pend_q || word_end) && ovf) begin
          ram_we_q <= 1'b0;
          pend_q <= 1'b0;
          error_q <= 1'b1;
          done_q <= 1'b1;
          st_q <= DONE;
        end else if (in_valid && in_ready) begin
          ram_we_q <= 1'b1;
          ram_addr_q <= ptr_q[ADDR_W-1:0];
          ram_wdata_q <= in_data[WORD_W-1 -: 8];
          sh_q <= in_data << 8;
          ptr_q <= ptr_q + 1'b1;
          bcnt_q <= '0;
          pend_q <= 1'b1;
          last_q <= in_last;
        end else if (pend_q && !word_end) begin
          ram_we_q <= 1'b1;
          ram_addr_q <= ptr_q[ADDR_W-1:0];
          ram_wdata_q <= sh_q[WORD_W-1 -: 8];
          sh_q <= sh_q << 8;
          ptr_q <= ptr_q + 1'b1;
          bcnt_q <= bcnt_q + 8'd1;
        end else begin
          ram_we_q <= 1'b0;
          pend_q <= 1'b0;
        end
        DONE: begin
          ram_we_q <= 1'b0;
          st_q <= IDLE;
        end
        default: st_q <= IDLE;
      endcase
    end
  end

  assign ram_addr = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_we = ram_we_q;
  assign busy = st_q != IDLE;
  assign done = done_q;
  assign error = error_q;
  assign filter_offset = foff_q;
  assign dense_offset = doff_q;
endmodule
